// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU-side byte-wide memory initiator.
package cpu_mem_pkg;

   localparam int unsigned MEM_ADDR_W  = 16;
   localparam int unsigned MEM_DATA_W  = 8;
   localparam int unsigned RD_WAIT_MAX = 7;
   localparam int unsigned WAIT_CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } mem_state_e;

endpackage

// File: rtl/mem_bus_master.sv
// Turns CPU load/store requests into byte-wide memory strobes; 16-bit words are
// split into two little-endian byte accesses, loads may insert read wait states.
module mem_bus_master
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = MEM_ADDR_W,
   parameter int unsigned DATA_W  = MEM_DATA_W,
   parameter int unsigned RD_WAIT = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic                  req_word,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic                  resp_valid,
   output logic [2*DATA_W-1:0]   resp_rdata,
   output logic                  read,
   output logic                  write,
   output logic [ADDR_W-1:0]     ar_out,
   output logic [DATA_W-1:0]     mem_input,
   input  logic [DATA_W-1:0]     mem_output
);

   mem_state_e              r_state;
   logic                    r_ready;
   logic                    r_resp_valid;
   logic [2*DATA_W-1:0]     r_resp_rdata;
   logic                    r_read;
   logic                    r_write;
   logic [ADDR_W-1:0]       r_ar;
   logic [DATA_W-1:0]       r_mem_in;
   logic                    r_is_write;
   logic                    r_word;
   logic [DATA_W-1:0]       r_wdata_hi;
   logic [DATA_W-1:0]       r_rd_lo;
   logic [WAIT_CNT_W-1:0]   r_wait;

   logic                    w_byte_done;

   // A store byte takes one strobe cycle; a load byte ends when the wait count runs out.
   assign w_byte_done = r_is_write || (r_wait == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_ready      <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_ar         <= '0;
         r_mem_in     <= '0;
         r_is_write   <= 1'b0;
         r_word       <= 1'b0;
         r_wdata_hi   <= '0;
         r_rd_lo      <= '0;
         r_wait       <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid && r_ready) begin
                  r_ready    <= 1'b0;
                  r_is_write <= req_write;
                  r_word     <= req_word;
                  r_wdata_hi <= req_wdata[2*DATA_W-1:DATA_W];
                  r_ar       <= req_addr;
                  r_mem_in   <= req_wdata[DATA_W-1:0];
                  r_read     <= !req_write;
                  r_write    <= req_write;
                  r_wait     <= WAIT_CNT_W'(RD_WAIT);
                  r_state    <= ACC0;
               end
            end
            ACC0, ACC1: begin
               if (!w_byte_done) begin
                  r_wait <= r_wait - WAIT_CNT_W'(1);
               end else if ((r_state == ACC0) && r_word) begin
                  // Second byte follows immediately; strobe stays asserted.
                  r_rd_lo  <= mem_output;
                  r_ar     <= r_ar + ADDR_W'(1);
                  r_mem_in <= r_wdata_hi;
                  r_wait   <= WAIT_CNT_W'(RD_WAIT);
                  r_state  <= ACC1;
               end else begin
                  r_read       <= 1'b0;
                  r_write      <= 1'b0;
                  r_resp_valid <= 1'b1;
                  if (!r_is_write) begin
                     r_resp_rdata <= r_word ? {mem_output, r_rd_lo}
                                            : {{DATA_W{1'b0}}, mem_output};
                  end
                  r_state <= RESP;
               end
            end
            RESP: begin
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = r_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign read       = r_read;
   assign write      = r_write;
   assign ar_out     = r_ar;
   assign mem_input  = r_mem_in;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (RD_WAIT 0 and 2) on byte memories,
// directed scenarios plus random traffic against a shadow-memory model.
module tb_mem_bus_master;

   logic clk = 1'b0;
   logic rst;

   logic        req_valid_s  [2];
   logic        req_ready_s  [2];
   logic        req_write_s  [2];
   logic        req_word_s   [2];
   logic [15:0] req_addr_s   [2];
   logic [15:0] req_wdata_s  [2];
   logic        resp_valid_s [2];
   logic [15:0] resp_rdata_s [2];
   logic        read_s       [2];
   logic        write_s      [2];
   logic [15:0] ar_s         [2];
   logic [7:0]  mem_in_s     [2];
   logic [7:0]  mem_out_s    [2];

   logic [7:0]  bmem [2][65536];
   logic [7:0]  modl [2][65536];
   logic [15:0] last_rdata [2];

   logic [15:0] obs_addr [$];
   logic [7:0]  obs_wbyte [$];

   int checks = 0;
   int errors = 0;

   int          lat, n_rd, n_wr, n_both, n_busy;
   bit          tmo;
   logic [15:0] rd;

   always #5 clk = ~clk;

   mem_bus_master #(.ADDR_W(16), .DATA_W(8), .RD_WAIT(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]),
      .req_write(req_write_s[0]), .req_word(req_word_s[0]),
      .req_addr(req_addr_s[0]), .req_wdata(req_wdata_s[0]),
      .resp_valid(resp_valid_s[0]), .resp_rdata(resp_rdata_s[0]),
      .read(read_s[0]), .write(write_s[0]), .ar_out(ar_s[0]),
      .mem_input(mem_in_s[0]), .mem_output(mem_out_s[0])
   );

   mem_bus_master #(.ADDR_W(16), .DATA_W(8), .RD_WAIT(2)) u_dut2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]),
      .req_write(req_write_s[1]), .req_word(req_word_s[1]),
      .req_addr(req_addr_s[1]), .req_wdata(req_wdata_s[1]),
      .resp_valid(resp_valid_s[1]), .resp_rdata(resp_rdata_s[1]),
      .read(read_s[1]), .write(write_s[1]), .ar_out(ar_s[1]),
      .mem_input(mem_in_s[1]), .mem_output(mem_out_s[1])
   );

   // Bench memories: posedge write, combinational read
   always @(posedge clk) begin
      if (write_s[0] === 1'b1) bmem[0][ar_s[0]] = mem_in_s[0];
      if (write_s[1] === 1'b1) bmem[1][ar_s[1]] = mem_in_s[1];
   end
   assign mem_out_s[0] = bmem[0][ar_s[0]];
   assign mem_out_s[1] = bmem[1][ar_s[1]];

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic run_txn(input int d, input bit wr, input bit word,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          output int o_lat, output logic [15:0] o_rd,
                          output int o_rd_n, output int o_wr_n, output int o_both,
                          output int o_busy, output bit o_tmo);
      int guard;
      obs_addr.delete();
      obs_wbyte.delete();
      o_rd_n = 0; o_wr_n = 0; o_both = 0; o_busy = 0; o_tmo = 0; o_lat = 0; o_rd = 'x;
      @(negedge clk);
      req_valid_s[d] = 1'b1;
      req_write_s[d] = wr;
      req_word_s[d]  = word;
      req_addr_s[d]  = addr;
      req_wdata_s[d] = wdata;
      guard = 0;
      while (req_ready_s[d] !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) o_tmo = 1;
      @(negedge clk);
      req_valid_s[d] = 1'b0;
      o_lat = 1;
      while (!o_tmo) begin
         if (read_s[d] === 1'b1) begin o_rd_n++; obs_addr.push_back(ar_s[d]); end
         if (write_s[d] === 1'b1) begin
            o_wr_n++;
            obs_addr.push_back(ar_s[d]);
            obs_wbyte.push_back(mem_in_s[d]);
         end
         if (read_s[d] === 1'b1 && write_s[d] === 1'b1) o_both++;
         if (req_ready_s[d] !== 1'b0) o_busy++;
         if (resp_valid_s[d] === 1'b1) begin
            o_rd = resp_rdata_s[d];
            break;
         end
         if (o_lat >= 40) o_tmo = 1;
         else begin
            o_lat++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid_s[d] = 1'b0; req_write_s[d] = 1'b0; req_word_s[d] = 1'b0;
         req_addr_s[d] = '0; req_wdata_s[d] = '0; last_rdata[d] = '0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({req_ready_s[d], resp_valid_s[d], read_s[d], write_s[d]} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_ctrl dut%0d got %b exp 1000", d,
                     {req_ready_s[d], resp_valid_s[d], read_s[d], write_s[d]});
         end
         checks++;
         if ({resp_rdata_s[d], ar_s[d], mem_in_s[d]} !== 40'h0) begin
            errors++;
            $display("FAIL rst_data dut%0d got rdata %h ar %h min %h exp zeros", d,
                     resp_rdata_s[d], ar_s[d], mem_in_s[d]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_byte_load();
      run_txn(0, 1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd, n_rd, n_wr, n_both, n_busy, tmo);
      checks++;
      if (tmo !== 1'b0 || lat !== 2) begin errors++; $display("FAIL bl_lat got %0d tmo %0d exp 2", lat, tmo); end
      checks++;
      if (n_rd !== 1 || n_wr !== 0 || obs_addr[0] !== 16'h0010) begin
         errors++; $display("FAIL bl_strobe got rd %0d wr %0d ar %h exp 1 0 0010", n_rd, n_wr, obs_addr[0]);
      end
      checks++;
      if (rd !== 16'h000F) begin errors++; $display("FAIL bl_data got %h exp 000f", rd); end
      last_rdata[0] = 16'h000F;
   endtask

   task automatic test_word_load();
      run_txn(0, 1'b0, 1'b1, 16'h0010, 16'h0000, lat, rd, n_rd, n_wr, n_both, n_busy, tmo);
      checks++;
      if (lat !== 3 || n_busy !== 0) begin errors++; $display("FAIL wl_lat got %0d busy_ready %0d exp 3 0", lat, n_busy); end
      checks++;
      if (n_rd !== 2 || obs_addr[0] !== 16'h0010 || obs_addr[1] !== 16'h0011) begin
         errors++; $display("FAIL wl_addr got n %0d %h %h exp 2 0010 0011", n_rd, obs_addr[0], obs_addr[1]);
      end
      checks++;
      if (rd !== 16'h3F0F) begin errors++; $display("FAIL wl_data got %h exp 3f0f", rd); end
      last_rdata[0] = 16'h3F0F;
   endtask

   task automatic test_word_store();
      run_txn(0, 1'b1, 1'b1, 16'h0020, 16'hBEEF, lat, rd, n_rd, n_wr, n_both, n_busy, tmo);
      checks++;
      if (lat !== 3 || n_wr !== 2 || n_rd !== 0) begin
         errors++; $display("FAIL ws_lat got lat %0d wr %0d rd %0d exp 3 2 0", lat, n_wr, n_rd);
      end
      checks++;
      if (obs_wbyte[0] !== 8'hEF || obs_wbyte[1] !== 8'hBE || obs_addr[1] !== 16'h0021) begin
         errors++; $display("FAIL ws_bus got %h %h ar1 %h exp ef be 0021", obs_wbyte[0], obs_wbyte[1], obs_addr[1]);
      end
      checks++;
      if (bmem[0][16'h0020] !== 8'hEF || bmem[0][16'h0021] !== 8'hBE) begin
         errors++; $display("FAIL ws_mem got %h %h exp ef be", bmem[0][16'h0020], bmem[0][16'h0021]);
      end
      checks++;
      if (rd !== last_rdata[0]) begin errors++; $display("FAIL ws_rdata_hold got %h exp %h", rd, last_rdata[0]); end
      modl[0][16'h0020] = 8'hEF;
      modl[0][16'h0021] = 8'hBE;
      run_txn(0, 1'b0, 1'b1, 16'h0020, 16'h0000, lat, rd, n_rd, n_wr, n_both, n_busy, tmo);
      checks++;
      if (rd !== 16'hBEEF) begin errors++; $display("FAIL ws_readback got %h exp beef", rd); end
      last_rdata[0] = 16'hBEEF;
   endtask

   task automatic test_wrap();
      run_txn(0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, rd, n_rd, n_wr, n_both, n_busy, tmo);
      checks++;
      if (obs_addr[0] !== 16'hFFFF || obs_addr[1] !== 16'h0000) begin
         errors++; $display("FAIL wrap_addr got %h %h exp ffff 0000", obs_addr[0], obs_addr[1]);
      end
      checks++;
      if (rd !== 16'h01A5) begin errors++; $display("FAIL wrap_data got %h exp 01a5", rd); end
      last_rdata[0] = 16'h01A5;
   endtask

   task automatic test_wait_states();
      int cyc, rdc, busy, bad_ar;
      logic [15:0] got;
      @(negedge clk);
      req_valid_s[1] = 1'b1; req_write_s[1] = 1'b0; req_word_s[1] = 1'b0;
      req_addr_s[1] = 16'h0001; req_wdata_s[1] = '0;
      checks++;
      if (req_ready_s[1] !== 1'b1) begin errors++; $display("FAIL ws2_ready_idle got %b exp 1", req_ready_s[1]); end
      @(negedge clk);
      // A second request is raised while the first is still in flight
      req_addr_s[1] = 16'h0010;
      cyc = 1; rdc = 0; busy = 0; bad_ar = 0; got = 'x;
      while (cyc <= 12) begin
         if (read_s[1] === 1'b1) begin rdc++; if (ar_s[1] !== 16'h0001) bad_ar++; end
         if (resp_valid_s[1] === 1'b1) begin got = resp_rdata_s[1]; break; end
         if (req_ready_s[1] !== 1'b0) busy++;
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (cyc !== 4 || rdc !== 3 || bad_ar !== 0) begin
         errors++; $display("FAIL ws2_timing got lat %0d reads %0d bad_ar %0d exp 4 3 0", cyc, rdc, bad_ar);
      end
      checks++;
      if (got !== 16'h0010 || busy !== 0) begin
         errors++; $display("FAIL ws2_first got %h busy_ready %0d exp 0010 0", got, busy);
      end
      @(negedge clk);
      checks++;
      if (req_ready_s[1] !== 1'b1 || read_s[1] !== 1'b0) begin
         errors++; $display("FAIL ws2_reaccept got ready %b read %b exp 1 0", req_ready_s[1], read_s[1]);
      end
      @(negedge clk);
      req_valid_s[1] = 1'b0;
      checks++;
      if (read_s[1] !== 1'b1 || ar_s[1] !== 16'h0010) begin
         errors++; $display("FAIL ws2_second_start got read %b ar %h exp 1 0010", read_s[1], ar_s[1]);
      end
      cyc = 1; got = 'x;
      while (cyc <= 12) begin
         if (resp_valid_s[1] === 1'b1) begin got = resp_rdata_s[1]; break; end
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (cyc !== 4 || got !== 16'h000F) begin
         errors++; $display("FAIL ws2_second got lat %0d data %h exp 4 000f", cyc, got);
      end
      last_rdata[1] = 16'h000F;
   endtask

   task automatic test_random();
      int d, wt, nb, exp_lat, idx, bad;
      bit wr, word;
      logic [15:0] addr, a1, wdata, exp_rd, expa;
      logic [7:0] expb;
      for (int t = 0; t < 40; t++) begin
         d     = int'($urandom_range(0, 1));
         wr    = 1'($urandom);
         word  = 1'($urandom);
         addr  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'(16'h0020 + $urandom_range(0, 31));
         wdata = 16'($urandom);
         a1    = addr + 16'd1;
         wt    = (d == 1) ? 2 : 0;
         nb    = word ? 2 : 1;
         exp_lat = wr ? nb + 1 : nb * (wt + 1) + 1;
         exp_rd  = wr ? last_rdata[d] : {word ? modl[d][a1] : 8'h00, modl[d][addr]};
         run_txn(d, wr, word, addr, wdata, lat, rd, n_rd, n_wr, n_both, n_busy, tmo);
         checks++;
         if (tmo !== 1'b0 || lat !== exp_lat) begin
            errors++; $display("FAIL rnd%0d_lat dut%0d wr%0d word%0d got %0d exp %0d", t, d, wr, word, lat, exp_lat);
         end
         checks++;
         if (n_rd !== (wr ? 0 : nb * (wt + 1)) || n_wr !== (wr ? nb : 0) || n_both !== 0 || n_busy !== 0) begin
            errors++; $display("FAIL rnd%0d_strobes got rd %0d wr %0d both %0d busy %0d", t, n_rd, n_wr, n_both, n_busy);
         end
         bad = 0;
         for (int k = 0; k < obs_addr.size(); k++) begin
            idx  = k / (wr ? 1 : wt + 1);
            expa = (idx == 0) ? addr : a1;
            expb = (idx == 0) ? wdata[7:0] : wdata[15:8];
            if (obs_addr[k] !== expa) bad++;
            if (wr && obs_wbyte[k] !== expb) bad++;
         end
         checks++;
         if (bad !== 0) begin errors++; $display("FAIL rnd%0d_bus got %0d bad beats exp 0", t, bad); end
         checks++;
         if (rd !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", t, rd, exp_rd); end
         if (wr) begin
            modl[d][addr] = wdata[7:0];
            if (word) modl[d][a1] = wdata[15:8];
            checks++;
            if (bmem[d][addr] !== modl[d][addr] || bmem[d][a1] !== modl[d][a1]) begin
               errors++; $display("FAIL rnd%0d_mem got %h %h exp %h %h", t, bmem[d][addr], bmem[d][a1],
                                  modl[d][addr], modl[d][a1]);
            end
         end else begin
            last_rdata[d] = exp_rd;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] prev31;
      int rv;
      prev31 = bmem[0][16'h0031];
      @(negedge clk);
      req_valid_s[0] = 1'b1; req_write_s[0] = 1'b1; req_word_s[0] = 1'b1;
      req_addr_s[0] = 16'h0030; req_wdata_s[0] = 16'h1234;
      @(negedge clk);
      req_valid_s[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (write_s[0] !== 1'b1 || ar_s[0] !== 16'h0031 || mem_in_s[0] !== 8'h12) begin
         errors++; $display("FAIL rm_acc1 got write %b ar %h min %h exp 1 0031 12", write_s[0], ar_s[0], mem_in_s[0]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({req_ready_s[0], resp_valid_s[0], read_s[0], write_s[0]} !== 4'b1000 ||
          {resp_rdata_s[0], ar_s[0], mem_in_s[0]} !== 40'h0) begin
         errors++; $display("FAIL rm_async got ctrl %b rdata %h ar %h min %h exp 1000 zeros",
                            {req_ready_s[0], resp_valid_s[0], read_s[0], write_s[0]},
                            resp_rdata_s[0], ar_s[0], mem_in_s[0]);
      end
      @(negedge clk);
      checks++;
      if (bmem[0][16'h0030] !== 8'h34 || bmem[0][16'h0031] !== prev31) begin
         errors++; $display("FAIL rm_mem got %h %h exp 34 %h", bmem[0][16'h0030], bmem[0][16'h0031], prev31);
      end
      rst = 1'b0;
      rv = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid_s[0] !== 1'b0) rv++;
      end
      checks++;
      if (rv !== 0) begin errors++; $display("FAIL rm_no_resp got %0d resp cycles exp 0", rv); end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         bmem[0][i] = 8'h00; bmem[1][i] = 8'h00;
         modl[0][i] = 8'h00; modl[1][i] = 8'h00;
      end
      for (int d = 0; d < 2; d++) begin
         bmem[d][16'h0000] = 8'h01; bmem[d][16'h0001] = 8'h10;
         bmem[d][16'h0010] = 8'h0F; bmem[d][16'h0011] = 8'h3F;
         bmem[d][16'hFFFF] = 8'hA5;
         modl[d][16'h0000] = 8'h01; modl[d][16'h0001] = 8'h10;
         modl[d][16'h0010] = 8'h0F; modl[d][16'h0011] = 8'h3F;
         modl[d][16'hFFFF] = 8'hA5;
      end
      test_reset();
      test_byte_load();
      test_word_load();
      test_word_store();
      test_wrap();
      test_wait_states();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
